// File: rtl/sa_skew_feeder.sv
// Systolic-array operand feeder: streams X columns / W rows (last column first),
// with optional per-lane diagonal skew and a drain phase before completion.

module sa_skew_lane #(
    parameter int D_W   = 8,
    parameter int DEPTH = 1
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           clr_i,
    input  logic           en_i,
    input  logic [D_W-1:0] d_i,
    output logic [D_W-1:0] q_o
);
    logic [DEPTH-1:0][D_W-1:0] sh_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            sh_q <= '0;
        end else if (en_i) begin
            sh_q[0] <= d_i;
            for (int n = 1; n < DEPTH; n++) sh_q[n] <= sh_q[n-1];
        end
    end

    assign q_o = sh_q[DEPTH-1];
endmodule

module sa_skew_feeder #(
    parameter int D_W       = 8,
    parameter int X_R       = 16,
    parameter int W_C       = 16,
    parameter int M_DIM_MAX = 16,
    parameter int SKEW_EN   = 1
) (
    input  logic                                    I_CLK,
    input  logic                                    I_SYNC_RST,
    input  logic                                    I_START,
    input  logic                                    I_ABORT,
    input  logic [15:0]                             I_K_LEN,
    input  logic                                    I_PE_SHIFT,
    input  logic [X_R-1:0][M_DIM_MAX-1:0][D_W-1:0]  I_X_MATRIX,
    input  logic [M_DIM_MAX-1:0][W_C-1:0][D_W-1:0]  I_W_MATRIX,
    output logic [X_R-1:0][D_W-1:0]                 O_X_VECTOR,
    output logic [W_C-1:0][D_W-1:0]                 O_W_VECTOR,
    output logic                                    O_BUSY,
    output logic                                    O_OVER,
    output logic                                    O_ERR,
    output logic [15:0]                             O_STEP
);
    localparam int          MAX_LANES = (X_R > W_C) ? X_R : W_C;
    localparam logic [15:0] SKEW_D    = (SKEW_EN != 0) ? 16'(MAX_LANES - 1) : 16'd0;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [15:0] step_q, step_d;
    logic [15:0] k_q, k_d;
    logic        over_q, over_d;
    logic        err_q, err_d;
    logic        clr;
    logic        run;
    logic        adv;
    logic [15:0] last;
    logic [15:0] col;

    logic [X_R-1:0][D_W-1:0] ux, xl;
    logic [W_C-1:0][D_W-1:0] uw, wl;

    assign run  = (state_q == RUN);
    assign adv  = run & I_PE_SHIFT & ~I_ABORT;
    assign last = k_q - 16'd1 + SKEW_D;

    always_ff @(posedge I_CLK) begin
        if (I_SYNC_RST) begin
            state_q <= IDLE;
            step_q  <= '0;
            k_q     <= '0;
            over_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            k_q     <= k_d;
            over_q  <= over_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        k_d     = k_q;
        over_d  = 1'b0;
        err_d   = 1'b0;
        clr     = 1'b0;
        case (state_q)
            IDLE: begin
                if (I_START) begin
                    if (I_K_LEN >= 16'd1 && I_K_LEN <= 16'(M_DIM_MAX)) begin
                        k_d     = I_K_LEN;
                        step_d  = '0;
                        clr     = 1'b1;
                        state_d = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            RUN: begin
                // abort outranks shift; a late start here is silently ignored
                if (I_ABORT) begin
                    state_d = IDLE;
                    step_d  = '0;
                    clr     = 1'b1;
                end else if (I_PE_SHIFT) begin
                    if (step_q == last) begin
                        state_d = IDLE;
                        step_d  = '0;
                        over_d  = 1'b1;
                    end else begin
                        step_d = step_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reversed feed: step s selects inner index K-1-s; zero once the matrix is exhausted.
    always_comb begin
        ux  = '0;
        uw  = '0;
        col = k_q - 16'd1 - step_q;
        if (run && step_q < k_q) begin
            for (int k = 0; k < M_DIM_MAX; k++) begin
                if (col == 16'(k)) begin
                    for (int i = 0; i < X_R; i++) ux[i] = I_X_MATRIX[i][k];
                    for (int j = 0; j < W_C; j++) uw[j] = I_W_MATRIX[k][j];
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < X_R; g++) begin : g_x
            if (SKEW_EN != 0 && g > 0) begin : g_dly
                sa_skew_lane #(.D_W(D_W), .DEPTH(g)) u_lane (
                    .clk_i (I_CLK),
                    .rst_i (I_SYNC_RST),
                    .clr_i (clr),
                    .en_i  (adv),
                    .d_i   (ux[g]),
                    .q_o   (xl[g])
                );
            end else begin : g_pass
                assign xl[g] = ux[g];
            end
            assign O_X_VECTOR[g] = run ? xl[g] : '0;
        end
        for (g = 0; g < W_C; g++) begin : g_w
            if (SKEW_EN != 0 && g > 0) begin : g_dly
                sa_skew_lane #(.D_W(D_W), .DEPTH(g)) u_lane (
                    .clk_i (I_CLK),
                    .rst_i (I_SYNC_RST),
                    .clr_i (clr),
                    .en_i  (adv),
                    .d_i   (uw[g]),
                    .q_o   (wl[g])
                );
            end else begin : g_pass
                assign wl[g] = uw[g];
            end
            assign O_W_VECTOR[g] = run ? wl[g] : '0;
        end
    endgenerate

    assign O_BUSY = run;
    assign O_OVER = over_q;
    assign O_ERR  = err_q;
    assign O_STEP = step_q;
endmodule

// File: tb/tb_sa_skew_feeder.sv
// Bench for sa_skew_feeder: one unskewed and one skewed instance on shared inputs,
// checked against a scoreboard fed from a small reference model.

module tb_sa_skew_feeder;
    logic I_CLK = 1'b0;
    logic I_SYNC_RST = 1'b1;
    logic I_START = 1'b0;
    logic I_ABORT = 1'b0;
    logic [15:0] I_K_LEN = '0;
    logic I_PE_SHIFT = 1'b0;
    logic [3:0][3:0][7:0] xm, wm;

    logic [3:0][7:0] ox0, ow0, ox1, ow1;
    logic busy0, over0, err0, busy1, over1, err1;
    logic [15:0] step0, step1;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic busy;
        logic over;
        logic [15:0] step;
        logic [3:0][7:0] ox;
        logic [3:0][7:0] ow;
    } exp_t;
    exp_t sbq[$];

    always #5 I_CLK = ~I_CLK;

    sa_skew_feeder #(.D_W(8), .X_R(4), .W_C(4), .M_DIM_MAX(4), .SKEW_EN(0)) dut0 (
        .I_CLK(I_CLK), .I_SYNC_RST(I_SYNC_RST), .I_START(I_START), .I_ABORT(I_ABORT),
        .I_K_LEN(I_K_LEN), .I_PE_SHIFT(I_PE_SHIFT), .I_X_MATRIX(xm), .I_W_MATRIX(wm),
        .O_X_VECTOR(ox0), .O_W_VECTOR(ow0), .O_BUSY(busy0), .O_OVER(over0),
        .O_ERR(err0), .O_STEP(step0)
    );

    sa_skew_feeder #(.D_W(8), .X_R(4), .W_C(4), .M_DIM_MAX(4), .SKEW_EN(1)) dut1 (
        .I_CLK(I_CLK), .I_SYNC_RST(I_SYNC_RST), .I_START(I_START), .I_ABORT(I_ABORT),
        .I_K_LEN(I_K_LEN), .I_PE_SHIFT(I_PE_SHIFT), .I_X_MATRIX(xm), .I_W_MATRIX(wm),
        .O_X_VECTOR(ox1), .O_W_VECTOR(ow1), .O_BUSY(busy1), .O_OVER(over1),
        .O_ERR(err1), .O_STEP(step1)
    );

    // Reference: lane i at step s carries inner index K-1-(s-d), d = i when skewed.
    function automatic logic [3:0][7:0] mvec(input bit isw, input bit skew, input int K,
                                             input int s, input bit run);
        logic [3:0][7:0] v;
        v = '0;
        for (int i = 0; i < 4; i++) begin
            int t;
            t = s - (skew ? i : 0);
            if (run && t >= 0 && t < K)
                v[i] = isw ? 8'(128 + 16 * (K - 1 - t) + i) : 8'(16 * i + (K - 1 - t));
        end
        return v;
    endfunction

    task automatic do_reset();
        I_SYNC_RST = 1'b1;
        I_START = 1'b0;
        I_ABORT = 1'b0;
        I_PE_SHIFT = 1'b0;
        @(negedge I_CLK);
        I_SYNC_RST = 1'b0;
    endtask

    task automatic start(input int K);
        I_START = 1'b1;
        I_K_LEN = 16'(K);
        @(negedge I_CLK);
        I_START = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({busy0, over0, err0, step0, ox0, ow0} !== '0 ||
            {busy1, over1, err1, step1, ox1, ow1} !== '0) begin
            n_fail++;
            $display("FAIL reset: dut0=%h dut1=%h required all zero",
                     {busy0, over0, err0, step0, ox0, ow0}, {busy1, over1, err1, step1, ox1, ow1});
        end
    endtask

    task automatic test_stream(input bit skew, input int K, input bit stall);
        exp_t e, g;
        int step_m, last, busy_dut, c;
        bit run_m, over_m, shift;
        do_reset();
        start(K);
        last = K - 1 + (skew ? 3 : 0);
        step_m = 0; run_m = 1; over_m = 0; busy_dut = 0; c = 0;
        while ((run_m || over_m) && c < 80) begin
            e.busy = run_m; e.over = over_m; e.step = 16'(step_m);
            e.ox = mvec(0, skew, K, step_m, run_m);
            e.ow = mvec(1, skew, K, step_m, run_m);
            sbq.push_back(e);
            g = skew ? {busy1, over1, step1, ox1, ow1} : {busy0, over0, step0, ox0, ow0};
            e = sbq.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL stream skew=%0d K=%0d cyc=%0d got=%h required=%h", skew, K, c, g, e);
            end
            if (skew && K == 4 && run_m && step_m == 3) begin
                n_checks++;
                if (ox1[3] !== 8'h33) begin
                    n_fail++;
                    $display("FAIL skew_x3_step3 got=%h required=33", ox1[3]);
                end
            end
            if (skew && K == 2 && run_m && step_m == 2) begin
                n_checks++;
                if (ox1[1] !== 8'h10) begin
                    n_fail++;
                    $display("FAIL stall_x1_step2 got=%h required=10", ox1[1]);
                end
            end
            if (g.busy) busy_dut++;
            shift = stall ? (c % 3 == 0) : 1'b1;
            I_PE_SHIFT = shift;
            over_m = 0;
            if (run_m && shift) begin
                if (step_m == last) begin
                    run_m = 0; step_m = 0; over_m = 1;
                end else begin
                    step_m++;
                end
            end
            c++;
            @(negedge I_CLK);
        end
        I_PE_SHIFT = 1'b0;
        n_checks++;
        if (run_m || busy_dut != (stall ? 3 * last + 1 : last + 1)) begin
            n_fail++;
            $display("FAIL busy_len skew=%0d K=%0d got=%0d required=%0d", skew, K, busy_dut,
                     stall ? 3 * last + 1 : last + 1);
        end
        n_checks++;
        if ((skew ? over1 : over0) !== 1'b0) begin
            n_fail++;
            $display("FAIL over_single_cycle skew=%0d got=1 required=0", skew);
        end
    endtask

    task automatic test_reject();
        int klist[2] = '{0, 5};
        do_reset();
        foreach (klist[n]) begin
            start(klist[n]);
            n_checks++;
            if ({err0, err1, busy0, busy1} !== 4'b1100) begin
                n_fail++;
                $display("FAIL reject_err K=%0d got=%b required=1100", klist[n], {err0, err1, busy0, busy1});
            end
            @(negedge I_CLK);
            n_checks++;
            if ({err0, err1, busy0, busy1} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reject_pulse K=%0d got=%b required=0000", klist[n], {err0, err1, busy0, busy1});
            end
        end
        start(4);
        I_PE_SHIFT = 1'b1;
        I_START = 1'b1;
        I_K_LEN = 16'd1;
        @(negedge I_CLK);
        I_START = 1'b0;
        n_checks++;
        if ({err0, err1, busy0, step0} !== {1'b0, 1'b0, 1'b1, 16'd1}) begin
            n_fail++;
            $display("FAIL start_in_run got err=%b%b busy=%b step=%0d required err=00 busy=1 step=1",
                     err0, err1, busy0, step0);
        end
        repeat (3) @(negedge I_CLK);
        I_PE_SHIFT = 1'b0;
        n_checks++;
        if ({over0, busy0, ox0} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL start_in_run_over got over=%b busy=%b ox=%h required over=1 busy=0 ox=0",
                     over0, busy0, ox0);
        end
    endtask

    task automatic test_abort(input bit use_rst);
        exp_t e, g;
        do_reset();
        start(4);
        I_PE_SHIFT = 1'b1;
        repeat (2) @(negedge I_CLK);
        n_checks++;
        if (step1 !== 16'd2) begin
            n_fail++;
            $display("FAIL abort_pre_step rst=%0d got=%0d required=2", use_rst, step1);
        end
        if (use_rst) I_SYNC_RST = 1'b1;
        else I_ABORT = 1'b1;
        @(negedge I_CLK);
        I_SYNC_RST = 1'b0;
        I_ABORT = 1'b0;
        I_PE_SHIFT = 1'b0;
        n_checks++;
        if ({busy0, over0, busy1, over1, ox0, ow0, ox1, ow1} !== '0) begin
            n_fail++;
            $display("FAIL abort_idle rst=%0d got=%h required=0", use_rst,
                     {busy0, over0, busy1, over1, ox0, ow0, ox1, ow1});
        end
        @(negedge I_CLK);
        n_checks++;
        if ({over0, over1} !== 2'b00) begin
            n_fail++;
            $display("FAIL abort_no_over rst=%0d got=%b required=00", use_rst, {over0, over1});
        end
        start(4);
        for (int s = 0; s < 3; s++) begin
            e.busy = 1'b1; e.over = 1'b0; e.step = 16'(s);
            e.ox = mvec(0, 1, 4, s, 1);
            e.ow = mvec(1, 1, 4, s, 1);
            sbq.push_back(e);
            g = {busy1, over1, step1, ox1, ow1};
            e = sbq.pop_front();
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL restart rst=%0d step=%0d got=%h required=%h", use_rst, s, g, e);
            end
            I_PE_SHIFT = 1'b1;
            @(negedge I_CLK);
            I_PE_SHIFT = 1'b0;
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        do_reset();
        start(2);
        I_PE_SHIFT = 1'b1;
        repeat (2) @(negedge I_CLK);
        I_PE_SHIFT = 1'b0;
        n_checks++;
        if ({over0, busy0} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_over got over=%b busy=%b required over=1 busy=0", over0, busy0);
        end
        start(2);
        n_checks++;
        if ({over0, busy0, step0, ox0} !== {1'b0, 1'b1, 16'd0, mvec(0, 0, 2, 0, 1)}) begin
            n_fail++;
            $display("FAIL b2b_restart got over=%b busy=%b step=%0d ox=%h required over=0 busy=1 step=0 ox=%h",
                     over0, busy0, step0, ox0, mvec(0, 0, 2, 0, 1));
        end
        do_reset();
        I_SYNC_RST = 1'b1;
        I_START = 1'b1;
        I_K_LEN = 16'd3;
        @(negedge I_CLK);
        I_SYNC_RST = 1'b0;
        I_START = 1'b0;
        n_checks++;
        if ({busy0, busy1, err0, err1} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_beats_start got=%b required=0000", {busy0, busy1, err0, err1});
        end
        @(negedge I_CLK);
        n_checks++;
        if ({busy0, busy1} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_beats_start_hold got=%b required=00", {busy0, busy1});
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                xm[i][k] = 8'(16 * i + k);
                wm[k][i] = 8'(128 + 16 * k + i);
            end
        @(negedge I_CLK);
        test_reset();
        test_stream(1'b0, 4, 1'b0);
        test_stream(1'b1, 4, 1'b0);
        test_stream(1'b1, 2, 1'b1);
        test_reject();
        test_abort(1'b0);
        test_abort(1'b1);
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
